// File: rtl/mdu_div_if.sv
// Request/response bundle between EX-stage pipeline control and the iterative divider.
// The master issues operations; the slave (divider) reports busy/done and the result.
interface mdu_div_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [2:0]      mdu_op;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] mdu_result;

  modport master (
    output start, rs1, rs2, mdu_op,
    input  busy, done, mdu_result
  );

  modport slave (
    input  start, rs1, rs2, mdu_op,
    output busy, done, mdu_result
  );
endinterface

// File: rtl/mdu_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle on magnitudes; sign fix-up in a final cycle.
module mdu_div #(
  parameter int unsigned XLEN = 32
) (
  input  logic      i_clk,
  input  logic      i_rst,
  mdu_div_if.slave  io_bus
);
  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_div;
  logic [XLEN-1:0] r_result;
  logic [CntW-1:0] r_cnt;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_sel_rem;

  logic            w_accept;
  logic            w_signed;
  logic            w_sign1;
  logic            w_sign2;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_special;
  logic            w_last;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;
  logic [XLEN-1:0] w_special_res;
  logic [XLEN-1:0] w_fix_val;
  logic [XLEN-1:0] w_fix_res;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_trial;

  assign w_accept   = (r_state == StIdle) && io_bus.start && io_bus.mdu_op[2];
  assign w_signed   = ~io_bus.mdu_op[0];
  assign w_sign1    = w_signed & io_bus.rs1[XLEN-1];
  assign w_sign2    = w_signed & io_bus.rs2[XLEN-1];
  assign w_abs1     = w_sign1 ? -io_bus.rs1 : io_bus.rs1;
  assign w_abs2     = w_sign2 ? -io_bus.rs2 : io_bus.rs2;
  assign w_div_zero = (io_bus.rs2 == '0);
  assign w_ovf      = w_signed && (io_bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (io_bus.rs2 == '1);
  assign w_special  = w_div_zero | w_ovf;

  // Divide-by-zero and signed overflow finish without iterating.
  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = io_bus.mdu_op[1] ? io_bus.rs1 : '1;
    end else begin
      w_special_res = io_bus.mdu_op[1] ? '0 : io_bus.rs1;
    end
  end

  assign w_last    = (r_cnt == CntW'(XLEN - 1));
  assign w_rem_sh  = {r_rem, r_quo[XLEN-1]};
  assign w_trial   = w_rem_sh - {1'b0, r_div};
  assign w_fix_val = r_sel_rem ? r_rem : r_quo;
  assign w_fix_res = (r_sel_rem ? r_neg_r : r_neg_q) ? -w_fix_val : w_fix_val;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_nxt = w_special ? StDone : StCalc;
      end
      StCalc: begin
        if (w_last) w_state_nxt = StFix;
      end
      StFix:   w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    io_bus.busy = 1'b0;
    io_bus.done = 1'b0;
    unique case (r_state)
      StIdle:  io_bus.busy = 1'b0;
      StCalc:  io_bus.busy = 1'b1;
      StFix:   io_bus.busy = 1'b1;
      StDone: begin
        io_bus.busy = 1'b1;
        io_bus.done = 1'b1;
      end
      default: io_bus.busy = 1'b0;
    endcase
  end

  assign io_bus.mdu_result = r_result;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_sel_rem <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_rem     <= '0;
            r_quo     <= w_abs1;
            r_div     <= w_abs2;
            r_cnt     <= '0;
            r_neg_q   <= w_sign1 ^ w_sign2;
            r_neg_r   <= w_sign1;
            r_sel_rem <= io_bus.mdu_op[1];
            if (w_special) r_result <= w_special_res;
          end
        end
        StCalc: begin
          // Non-negative trial (MSB clear) means the divisor fits: keep difference, set bit.
          if (!w_trial[XLEN]) begin
            r_rem <= w_trial[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], 1'b1};
          end else begin
            r_rem <= w_rem_sh[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], 1'b0};
          end
          r_cnt <= r_cnt + CntW'(1);
        end
        StFix:   r_result <= w_fix_res;
        StDone:  r_cnt <= r_cnt;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_div.sv
// Directed self-checking bench for mdu_div: results, latency, done pulse width,
// special cases, ignored requests and reset abort.
module tb_mdu_div;
  localparam logic [2:0] OpDiv  = 3'b100;
  localparam logic [2:0] OpDivu = 3'b101;
  localparam logic [2:0] OpRem  = 3'b110;
  localparam logic [2:0] OpRemu = 3'b111;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mdu_div_if #(.XLEN(32)) bus ();

  mdu_div #(.XLEN(32)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one op and reports result, edges from start to done, and whether done was one cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit one_pulse);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mdu_op = op;
    bus.rs1    = a;
    bus.rs2    = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.rs1   = ~a;
    bus.rs2   = ~b;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.done) begin
      lat       = -1;
      res       = 'x;
      one_pulse = 1'b0;
    end else begin
      res = bus.mdu_result;
      @(posedge clk);
      #1;
      one_pulse = !bus.done && !bus.busy;
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.rs1    = '0;
    bus.rs2    = '0;
    bus.mdu_op = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mdu_result !== 32'h0) begin
      $display("FAIL reset_state: busy=%b done=%b result=%h, want 0 0 00000000",
               bus.busy, bus.done, bus.mdu_result);
      n_fail++;
    end
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mdu_op = 3'b000;
    bus.rs1    = 32'd9;
    bus.rs2    = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      $display("FAIL non_div_op_ignored: busy=%b done=%b, want 0 0", bus.busy, bus.done);
      n_fail++;
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] r;
    int          lat;
    bit          one;
    run_op(OpDivu, 32'd100, 32'd7, r, lat, one);
    n_tests++;
    if (r !== 32'd14) begin
      $display("FAIL divu_100_7: got %h, want %h", r, 32'd14); n_fail++;
    end
    n_tests++;
    if (lat !== 34) begin
      $display("FAIL divu_latency: got %0d, want 34", lat); n_fail++;
    end
    n_tests++;
    if (one !== 1'b1) begin
      $display("FAIL divu_done_width: single pulse=%b, want 1", one); n_fail++;
    end
    run_op(OpRemu, 32'd100, 32'd7, r, lat, one);
    n_tests++;
    if (r !== 32'd2 || lat !== 34) begin
      $display("FAIL remu_100_7: got %h lat %0d, want 00000002 lat 34", r, lat); n_fail++;
    end
    run_op(OpDivu, 32'hFFFF_FFFF, 32'd1, r, lat, one);
    n_tests++;
    if (r !== 32'hFFFF_FFFF) begin
      $display("FAIL divu_max_1: got %h, want ffffffff", r); n_fail++;
    end
    run_op(OpRemu, 32'hFFFF_FFFF, 32'h10, r, lat, one);
    n_tests++;
    if (r !== 32'hF) begin
      $display("FAIL remu_max_16: got %h, want 0000000f", r); n_fail++;
    end
    run_op(OpDivu, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, one);
    n_tests++;
    if (r !== 32'h0 || lat !== 34) begin
      $display("FAIL divu_not_overflow: got %h lat %0d, want 00000000 lat 34", r, lat);
      n_fail++;
    end
  endtask

  task automatic test_signed();
    logic [31:0] r;
    int          lat;
    bit          one;
    run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, r, lat, one);
    n_tests++;
    if (r !== 32'hFFFF_FFFD || lat !== 34) begin
      $display("FAIL div_m7_2: got %h lat %0d, want fffffffd lat 34", r, lat); n_fail++;
    end
    run_op(OpRem, 32'hFFFF_FFF9, 32'd2, r, lat, one);
    n_tests++;
    if (r !== 32'hFFFF_FFFF) begin
      $display("FAIL rem_m7_2: got %h, want ffffffff", r); n_fail++;
    end
    run_op(OpDiv, 32'd7, 32'hFFFF_FFFE, r, lat, one);
    n_tests++;
    if (r !== 32'hFFFF_FFFD) begin
      $display("FAIL div_7_m2: got %h, want fffffffd", r); n_fail++;
    end
    run_op(OpRem, 32'd7, 32'hFFFF_FFFE, r, lat, one);
    n_tests++;
    if (r !== 32'd1) begin
      $display("FAIL rem_7_m2: got %h, want 00000001", r); n_fail++;
    end
    run_op(OpRem, 32'hFFFF_FF9C, 32'd7, r, lat, one);
    n_tests++;
    if (r !== 32'hFFFF_FFFE) begin
      $display("FAIL rem_m100_7: got %h, want fffffffe", r); n_fail++;
    end
    run_op(OpDiv, 32'h8000_0000, 32'd1, r, lat, one);
    n_tests++;
    if (r !== 32'h8000_0000) begin
      $display("FAIL div_min_1: got %h, want 80000000", r); n_fail++;
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] r;
    int          lat;
    bit          one;
    run_op(OpDivu, 32'd5, 32'd0, r, lat, one);
    n_tests++;
    if (r !== 32'hFFFF_FFFF || lat !== 1) begin
      $display("FAIL divu_by_zero: got %h lat %0d, want ffffffff lat 1", r, lat); n_fail++;
    end
    n_tests++;
    if (one !== 1'b1) begin
      $display("FAIL div_zero_done_width: single pulse=%b, want 1", one); n_fail++;
    end
    run_op(OpRem, 32'd5, 32'd0, r, lat, one);
    n_tests++;
    if (r !== 32'd5 || lat !== 1) begin
      $display("FAIL rem_by_zero: got %h lat %0d, want 00000005 lat 1", r, lat); n_fail++;
    end
    run_op(OpDiv, 32'hFFFF_FFF9, 32'd0, r, lat, one);
    n_tests++;
    if (r !== 32'hFFFF_FFFF || lat !== 1) begin
      $display("FAIL div_by_zero: got %h lat %0d, want ffffffff lat 1", r, lat); n_fail++;
    end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    int          lat;
    bit          one;
    run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, one);
    n_tests++;
    if (r !== 32'h8000_0000 || lat !== 1) begin
      $display("FAIL div_overflow: got %h lat %0d, want 80000000 lat 1", r, lat); n_fail++;
    end
    run_op(OpRem, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, one);
    n_tests++;
    if (r !== 32'h0 || lat !== 1) begin
      $display("FAIL rem_overflow: got %h lat %0d, want 00000000 lat 1", r, lat); n_fail++;
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mdu_op = OpDivu;
    bus.rs1    = 32'd100;
    bus.rs2    = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      if (lat == 5) begin
        bus.start  = 1'b1;
        bus.mdu_op = OpRemu;
        bus.rs1    = 32'd50;
        bus.rs2    = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    n_tests++;
    if (bus.mdu_result !== 32'd14 || lat !== 34) begin
      $display("FAIL start_mid_calc: got %h lat %0d, want 0000000e lat 34",
               bus.mdu_result, lat);
      n_fail++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort();
    logic [31:0] r;
    int          lat;
    bit          one;
    bit          saw_done;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mdu_op = OpDivu;
    bus.rs1    = 32'd1000;
    bus.rs2    = 32'd10;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mdu_result !== 32'h0) begin
      $display("FAIL reset_abort_state: busy=%b done=%b result=%h, want 0 0 00000000",
               bus.busy, bus.done, bus.mdu_result);
      n_fail++;
    end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) saw_done = 1'b1;
    end
    n_tests++;
    if (saw_done !== 1'b0) begin
      $display("FAIL reset_abort_no_done: done seen=%b, want 0", saw_done); n_fail++;
    end
    run_op(OpRemu, 32'd1000, 32'd7, r, lat, one);
    n_tests++;
    if (r !== 32'd6 || lat !== 34) begin
      $display("FAIL after_reset_op: got %h lat %0d, want 00000006 lat 34", r, lat);
      n_fail++;
    end
  endtask

  task automatic test_reset_with_start();
    @(negedge clk);
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.mdu_op = OpDivu;
    bus.rs1    = 32'd5;
    bus.rs2    = 32'd0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mdu_result !== 32'h0) begin
      $display("FAIL reset_wins_start: busy=%b done=%b result=%h, want 0 0 00000000",
               bus.busy, bus.done, bus.mdu_result);
      n_fail++;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_start_ignored();
    test_reset_abort();
    test_reset_with_start();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
